// File: rtl/rr_select_stage.sv
`default_nettype none
// ============================================================================
// Module      : rr_select_stage
// Description : Round-robin front/back stage for an N:1 mux tree. Picks the
//               next requester in round-robin order, drives the tree's select
//               index, and captures the tree's output in a one-entry
//               registered output stage with a valid/ready handshake.
//               Optional grant statistics are built when RR_SELECT_STATS_EN
//               is defined; this adds the xfer_count port.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_select_stage #(
  parameter int N = 4,   // number of requesters, power of two, >= 2
  parameter int W = 32   // data width per requester
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [$clog2(N)-1:0] sel,
  input  logic [W-1:0]         mux_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data
`ifdef RR_SELECT_STATS_EN
  ,
  output logic [15:0]          xfer_count
`endif
);

  localparam int c_PTR_W = $clog2(N);

  // Round-robin pointer: index of the highest-priority requester.
  logic [c_PTR_W-1:0] ptr_q;
  logic [c_PTR_W-1:0] ptr_d;

  // One-entry output register.
  logic               out_valid_q;
  logic               out_valid_d;
  logic [W-1:0]       out_data_q;
  logic [W-1:0]       out_data_d;

  // Arbitration signals.
  logic [c_PTR_W-1:0] cand;
  logic [c_PTR_W-1:0] scan_idx;
  logic               found;
  logic               load_ok;
  logic               grant;

  // Scan from the pointer upward, wrapping naturally because N is a power of
  // two; with nothing valid the candidate rests on the pointer so sel only
  // moves when a grant advances the pointer.
  always_comb begin
    cand     = ptr_q;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = ptr_q + c_PTR_W'(k);
      if (!found && in_valid[scan_idx]) begin
        cand  = scan_idx;
        found = 1'b1;
      end
    end
  end

  // The output register can take a new word when empty or when it is being
  // drained this same cycle, which gives one word per clock.
  assign load_ok = !out_valid_q || out_ready;
  assign grant   = load_ok && (|in_valid);
  assign sel     = cand;

  // One-hot ready to the winning requester, only while a grant is taken.
  always_comb begin
    in_ready = '0;
    if (grant) begin
      in_ready[cand] = 1'b1;
    end
  end

  // Next-state for pointer and output register: load wins over drain.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (grant) begin
      ptr_d       = cand + c_PTR_W'(1);
      out_valid_d = 1'b1;
      out_data_d  = mux_out;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any pending word and restarts the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef RR_SELECT_STATS_EN
  logic [15:0] xfer_count_q;
  logic [15:0] xfer_count_d;

  // Saturating grant counter.
  always_comb begin
    xfer_count_d = xfer_count_q;
    if (grant && (xfer_count_q != 16'hFFFF)) begin
      xfer_count_d = xfer_count_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count_q <= '0;
    end else begin
      xfer_count_q <= xfer_count_d;
    end
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_select_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_select_stage
// Description : Directed self-checking bench for rr_select_stage (N=4, W=8).
//               The bench models the mux tree as in_data[sel].
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_select_stage;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [1:0]   sel;
  logic [W-1:0] mux_out;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef RR_SELECT_STATS_EN
  logic [15:0]  xfer_count;
`endif

  logic [W-1:0] in_data [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Mux tree model.
  assign mux_out = in_data[sel];

  rr_select_stage #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mux_out   (mux_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef RR_SELECT_STATS_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) in_data[i] = '0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", sel); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b exp 0000", in_ready); end
`ifdef RR_SELECT_STATS_EN
    checks++; if (xfer_count !== 16'h0000) begin errors++; $display("FAIL reset_xfer_count got %h exp 0000", xfer_count); end
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // All four valid: grants rotate 0,1,2,3,0 with one word per clock.
  task automatic test_rotation();
    logic [3:0] exp_rdy;
    logic [7:0] exp_data;
    in_data[0] = 8'hA0; in_data[1] = 8'hA1; in_data[2] = 8'hA2; in_data[3] = 8'hA3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid  = 4'hF;
      out_ready = 1'b1;
      exp_rdy   = 4'b0001 << (k % 4);
      exp_data  = 8'hA0 + 8'(k % 4);
      #1;
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rot_in_ready[%0d] got %b exp %b", k, in_ready, exp_rdy); end
      checks++; if (sel !== 2'(k % 4)) begin errors++; $display("FAIL rot_sel[%0d] got %0d exp %0d", k, sel, k % 4); end
      @(posedge clk); #1;
      checks++; if (out_data !== exp_data) begin errors++; $display("FAIL rot_out_data[%0d] got %h exp %h", k, out_data, exp_data); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rot_out_valid[%0d] got %b exp 1", k, out_valid); end
    end
  endtask

  // Pointer is 1 on entry. Lone req 2 moves pointer to 3, lone req 2 again
  // keeps it at 3, then a lone req 0 is reached by wrapping.
  task automatic test_wrap();
    @(negedge clk);
    in_valid = 4'b0100; in_data[2] = 8'h22; out_ready = 1'b1;
    #1;
    checks++; if (sel !== 2'd2) begin errors++; $display("FAIL wrap1_sel got %0d exp 2", sel); end
    @(posedge clk); #1;
    checks++; if (out_data !== 8'h22) begin errors++; $display("FAIL wrap1_out_data got %h exp 22", out_data); end

    @(negedge clk);
    in_valid = 4'b0000;
    #1;
    checks++; if (sel !== 2'd3) begin errors++; $display("FAIL wrap_ptr3a_sel got %0d exp 3", sel); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL wrap_idle_in_ready got %b exp 0000", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain_valid got %b exp 0", out_valid); end

    @(negedge clk);
    in_valid = 4'b0100; in_data[2] = 8'h2B;
    #1;
    checks++; if (sel !== 2'd2) begin errors++; $display("FAIL wrap2_sel got %0d exp 2", sel); end
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL wrap2_in_ready got %b exp 0100", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_data !== 8'h2B) begin errors++; $display("FAIL wrap2_out_data got %h exp 2b", out_data); end

    @(negedge clk);
    in_valid = 4'b0000;
    #1;
    checks++; if (sel !== 2'd3) begin errors++; $display("FAIL wrap_ptr3b_sel got %0d exp 3", sel); end
    @(posedge clk); #1;

    @(negedge clk);
    in_valid = 4'b0001; in_data[0] = 8'h0C;
    #1;
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL wrap0_sel got %0d exp 0", sel); end
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL wrap0_in_ready got %b exp 0001", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_data !== 8'h0C) begin errors++; $display("FAIL wrap0_out_data got %h exp 0c", out_data); end
  endtask

  // Pointer is 1 on entry. Load 55 from req 1, stall 3 clocks, then release
  // and load req 2's word on the same clock the 55 is accepted.
  task automatic test_stall();
    @(negedge clk);
    in_valid = 4'b0010; in_data[1] = 8'h55; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL stall_load_in_ready got %b exp 0010", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_data !== 8'h55) begin errors++; $display("FAIL stall_load_out_data got %h exp 55", out_data); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 4'hF; in_data[2] = 8'h66; out_ready = 1'b0;
      #1;
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL stall_in_ready[%0d] got %b exp 0000", k, in_ready); end
      checks++; if (sel !== 2'd2) begin errors++; $display("FAIL stall_sel[%0d] got %0d exp 2", k, sel); end
      @(posedge clk); #1;
      checks++; if (out_data !== 8'h55) begin errors++; $display("FAIL stall_out_data[%0d] got %h exp 55", k, out_data); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid[%0d] got %b exp 1", k, out_valid); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL release_in_ready got %b exp 0100", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_data !== 8'h66) begin errors++; $display("FAIL release_out_data got %h exp 66", out_data); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL release_out_valid got %b exp 1", out_valid); end
  endtask

  // Pointer is 3 on entry. Five idle clocks: drained after the first, data
  // and pointer hold.
  task automatic test_idle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 4'b0000; out_ready = 1'b1;
      #1;
      checks++; if (sel !== 2'd3) begin errors++; $display("FAIL idle_sel[%0d] got %0d exp 3", k, sel); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid[%0d] got %b exp 0", k, out_valid); end
      checks++; if (out_data !== 8'h66) begin errors++; $display("FAIL idle_out_data[%0d] got %h exp 66", k, out_data); end
    end
  endtask

  // Pointer is 3 on entry. Load from req 1 (pointer -> 2), then reset
  // between clock edges while the word is pending.
  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 4'b0010; in_data[1] = 8'h77; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", out_valid); end
    checks++; if (sel !== 2'd2) begin errors++; $display("FAIL mid_pre_sel got %0d exp 2", sel); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL mid_out_data got %h exp 00", out_data); end
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL mid_sel got %0d exp 0", sel); end
`ifdef RR_SELECT_STATS_EN
    checks++; if (xfer_count !== 16'h0000) begin errors++; $display("FAIL mid_xfer_count got %h exp 0000", xfer_count); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 4'hF; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL restart_in_ready got %b exp 0001", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_data !== 8'h0C) begin errors++; $display("FAIL restart_out_data got %h exp 0c", out_data); end
`ifdef RR_SELECT_STATS_EN
    checks++; if (xfer_count !== 16'h0001) begin errors++; $display("FAIL restart_xfer_count got %h exp 0001", xfer_count); end
`endif
  endtask

`ifdef RR_SELECT_STATS_EN
  // Count saturates at FFFF after 65540 more grants; reset clears it.
  task automatic test_stats();
    @(negedge clk);
    in_valid = 4'hF; out_ready = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    checks++; if (xfer_count !== 16'hFFFF) begin errors++; $display("FAIL stats_sat got %h exp ffff", xfer_count); end
    @(posedge clk); #1;
    checks++; if (xfer_count !== 16'hFFFF) begin errors++; $display("FAIL stats_hold got %h exp ffff", xfer_count); end
    rst_n = 1'b0;
    #1;
    checks++; if (xfer_count !== 16'h0000) begin errors++; $display("FAIL stats_reset got %h exp 0000", xfer_count); end
    in_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rotation();
    test_wrap();
    test_stall();
    test_idle();
    test_reset_mid();
`ifdef RR_SELECT_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
